keypad_scan_ctrl: RTL
=====================

# keypad_scan_ctrl

Scans a 4x4 matrix keypad and debounces it. The block drives one active-low column strobe at a time and samples the four active-low row returns. When a key is confirmed, it presents the 2-bit row index and the 2-bit column index on D0/D1/Q0/Q1 with a valid/ack handshake. It sits directly upstream of the key-code decoder in the keyboard controller, and D0/D1/Q0/Q1 connect pin-for-pin to that decoder. The decoder adds its own one-cycle register stage, so a confirmed key reaches BCDKey one cycle after it appears on D0/D1/Q0/Q1.

## Interface
- SCAN_DIV, 1000: cycles each column is strobed before its rows are sampled; minimum 3.
- DEBOUNCE_CYC, 20000: consecutive stable cycles required to confirm a press or a release; minimum 2.
- REPEAT_CYC, 500000: auto-repeat period in cycles; only used when KEYPAD_AUTOREPEAT_EN is defined.

- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- ROW  in  4  raw row returns, active-low (0 = key closed on the strobed column), asynchronous to CLK.
- COL  out  4  column strobes, one-hot active-low.
- D0  out  1  row index MSB.
- D1  out  1  row index LSB.
- Q0  out  1  column index MSB.
- Q1  out  1  column index LSB.
- KEY_VALID  out  1  D0/D1/Q0/Q1 hold a confirmed key; stays high until acknowledged.
- KEY_ACK  in  1  consumer accepts the key.
- KEY_HELD  out  1  high from key confirmation until its release is confirmed.

## Operation
- ROW passes through a 2-flop synchronizer; all decisions below use the synchronized value rs.
- SCAN state:
  - COL = ~(1<<c), where c is the column counter.
  - A divider counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1, the block samples rs.
  - If any rs bit is 0: latch r = lowest index with rs[r]==0, latch column c, clear the counter, go to DEBOUNCE.
  - Otherwise: c = c+1 modulo 4 (3 wraps to 0), divider restarts.
- DEBOUNCE state:
  - COL stays on c.
  - Each cycle rs[r]==0 increments the counter. On reaching DEBOUNCE_CYC-1, go to WAIT_ACK.
  - Any cycle with rs[r]==1: advance c and return to SCAN. Nothing is reported.
- WAIT_ACK state:
  - KEY_VALID=1 and KEY_HELD=1.
  - {D0,D1}=r and {Q0,Q1}=c; these are loaded on entry and stable while KEY_VALID=1.
  - Leave for HOLD when KEY_ACK=1 is sampled. A release while waiting does not cancel the key.
- HOLD state:
  - KEY_VALID=0, KEY_HELD=1, COL stays on c.
  - The counter counts consecutive rs[r]==1 cycles and clears on any rs[r]==0.
  - On reaching DEBOUNCE_CYC-1: KEY_HELD=0, advance c, go to SCAN.
- Multiple keys: the first column scanned that has a closure wins; within that column the lowest row wins. Other keys are ignored until release.
- D0/D1/Q0/Q1 retain the last confirmed key after KEY_VALID falls.

## Timing
- Reset values (RST_N=0 at a rising edge):
  - COL=4'b1110, D0=D1=Q0=Q1=0, KEY_VALID=0, KEY_HELD=0.
  - State SCAN, c=0, all counters 0, synchronizer flops 1.
  - Reset mid-operation aborts any state on the same edge.
- Each column is strobed for exactly SCAN_DIV cycles, so a full scan takes 4*SCAN_DIV cycles.
- Press latency, for a closure already stable before its column is strobed:
  - KEY_VALID rises SCAN_DIV + DEBOUNCE_CYC cycles after that column's strobe begins.
  - The first sample is taken SCAN_DIV-1 cycles after the strobe begins; SCAN_DIV>=3 covers the 2-cycle synchronizer latency.
- Handshake:
  - KEY_VALID falls on the edge after the edge that samples KEY_ACK=1.
  - KEY_ACK while KEY_VALID=0 is ignored.
  - KEY_ACK held high continuously accepts each key one cycle after it is presented.
- Release latency: KEY_HELD falls DEBOUNCE_CYC cycles after rs[r] first reads 1 continuously.
- Counter widths are $clog2 of the parameter; no counter wraps except c.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In HOLD, a repeat counter counts cycles while rs[r]==0. It clears on any rs[r]==1 and on entry to HOLD.
  - When it reaches REPEAT_CYC-1, the block re-enters WAIT_ACK with the same D0/D1/Q0/Q1, and KEY_VALID rises again.
- Undefined: no repeat counter is built; one KEY_VALID per press.

## Test plan
Use SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=32.
- Reset: hold RST_N=0 for 3 cycles, ROW=4'b1111 -> COL=1110, all outputs 0. After release, COL rotates 1110→1101→1011→0111→1110, changing every 4 cycles.
- Single press, row 2 / column 1:
  - Stimulus: ROW[2]=0 whenever COL[1]=0; KEY_ACK=1 on the second KEY_VALID cycle.
  - Required: KEY_VALID rises 12 cycles after COL=1101 begins, with {D0,D1}=10 and {Q0,Q1}=01; the decoder shows BCDKey=1001 one cycle later. KEY_VALID falls one cycle after the ack.
- Bounce: ROW[0] low for 5 cycles then high during DEBOUNCE -> no KEY_VALID, scan resumes at the next column.
- Two keys in column 3, rows 1 and 3 -> report {D0,D1}=01, {Q0,Q1}=11.
- Release while waiting: key released before KEY_ACK -> KEY_VALID stays high until ack. KEY_HELD falls 8 cycles after the ack, since the key is already released.
- With KEYPAD_AUTOREPEAT_EN defined and the key held after ack: KEY_VALID re-asserts every 32 cycles after each ack, with the same code. Without the macro, it never re-asserts.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// Key report bus between the keypad scanner (master) and the key-code decoder (slave).
// Signal names match the decoder pins one-for-one.
interface keypad_scan_ctrl_if;
  logic D0;
  logic D1;
  logic Q0;
  logic Q1;
  logic KEY_VALID;
  logic KEY_ACK;
  logic KEY_HELD;

  modport master (
    output D0, D1, Q0, Q1, KEY_VALID, KEY_HELD,
    input  KEY_ACK
  );

  modport slave (
    input  D0, D1, Q0, Q1, KEY_VALID, KEY_HELD,
    output KEY_ACK
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner/debouncer: press reported SCAN_DIV+DEBOUNCE_CYC cycles after its column strobe; KEY_VALID holds (scan stalls) until KEY_ACK.
// Define KEYPAD_AUTOREPEAT_EN to re-present a held key every REPEAT_CYC cycles after each ack.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_CYC   = 500000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [3:0]         ROW,
  output logic [3:0]         COL,
  keypad_scan_ctrl_if.master key_if
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYC);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         c_q, c_d;
  logic [1:0]         r_q, r_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DEB_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         key_q, key_d;
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic               key_valid;
  logic               key_held;
  logic               row_open;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC);
  logic [REP_W-1:0]   rep_q, rep_d;
`else
  logic               unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYC > 0);
`endif

  function automatic logic [1:0] first_low(input logic [3:0] v);
    if (!v[0])      first_low = 2'd0;
    else if (!v[1]) first_low = 2'd1;
    else if (!v[2]) first_low = 2'd2;
    else            first_low = 2'd3;
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_SCAN;
      c_q     <= '0;
      r_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // sync2_q is the synchronized row bus; row_open tracks only the latched row.
  assign row_open = sync2_q[r_q];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    sync1_d = ROW;
    sync2_d = sync1_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_d = '0;
          if (sync2_q != 4'hF) begin
            r_d     = first_low(sync2_q);
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            c_d = c_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!row_open) begin
          if (cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
            cnt_d   = '0;
            key_d   = {r_q, c_q};
            state_d = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          c_d     = c_q + 2'd1;
          state_d = ST_SCAN;
        end
      end
      ST_WAIT_ACK: begin
        if (key_if.KEY_ACK) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (row_open) begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d = '0;
`endif
          if (cnt_q == DEB_W'(DEBOUNCE_CYC - 1)) begin
            cnt_d   = '0;
            c_d     = c_q + 2'd1;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rep_q == REP_W'(REPEAT_CYC - 1)) begin
            rep_d   = '0;
            state_d = ST_WAIT_ACK;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    COL       = ~(4'b0001 << c_q);
    key_valid = (state_q == ST_WAIT_ACK);
    key_held  = (state_q == ST_WAIT_ACK) || (state_q == ST_HOLD);
  end

  assign key_if.D0        = key_q[3];
  assign key_if.D1        = key_q[2];
  assign key_if.Q0        = key_q[1];
  assign key_if.Q1        = key_q[0];
  assign key_if.KEY_VALID = key_valid;
  assign key_if.KEY_HELD  = key_held;

endmodule
